mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Memory-stage load/store unit sitting between the EX/MEM pipeline register and the MEM/WB register.
- Takes the EX-stage result (address) and store data, and runs a req/ack transaction to data memory.
- Aligns and sign/zero-extends load data; forwards control and result to MEM/WB.
- Stalls upstream stages while a memory access is outstanding.

Parameters:
XLEN, 64, datapath and address width (byte-addressed, 8 byte lanes)

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  EX/MEM holds a valid instruction
MemRead  in  1  load
MemWrite  in  1  store
RegWrite  in  1  writeback enable, passed through
MemtoReg  in  1  writeback mux select, passed through
funct3  in  3  access size/sign
Result  in  XLEN  ALU result = memory address
Write_Data  in  XLEN  store data (rs2), low-aligned
RD  in  5  destination register
stall  out  1  freeze IF/ID/EX and EX/MEM
out_valid  out  1  outputs valid for MEM/WB
RegWrite_o, MemtoReg_o  out  1  registered pass-through
Read_Data_Memory  out  XLEN  aligned, extended load data
Result_o  out  XLEN  registered Result
RD_o  out  5  registered RD
dmem_req  out  1  request, held until ack
dmem_we  out  1  1 = write
dmem_addr  out  XLEN  doubleword-aligned address (low 3 bits zero)
dmem_wdata  out  XLEN  lane-shifted store data
dmem_wstrb  out  8  byte enables
dmem_ack  in  1  one-cycle completion pulse
dmem_rdata  in  XLEN  read doubleword, valid with dmem_ack

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0. dmem_req deasserts immediately and a pending access is abandoned.
- mem_op = in_valid & (MemRead | MemWrite). If both MemRead and MemWrite are set, the access is treated as a store.
- FSM states IDLE and WAIT.
- IDLE, non-mem op: at the next edge, out_valid=in_valid and the pass-through regs load. stall=0. Latency is 1 cycle.
- IDLE, mem op: stall=1 combinationally. At the edge, latch the request (addr, we, wstrb, wdata, funct3, addr[2:0], ctrl, RD, Result) and go to WAIT. out_valid=0 at that edge.
- WAIT: dmem_req=1 with stable addr/we/wdata/wstrb. stall = ~dmem_ack.
  - dmem_ack=1: at the edge, Read_Data_Memory = extend(dmem_rdata >> 8*addr[2:0]) for loads, 0 for stores. out_valid=1, go to IDLE.
  - Minimum memory-op latency is 2 cycles (accept, ack).
- In WAIT, in_valid, funct3 and the other inputs are ignored. In IDLE, dmem_ack is ignored.
- funct3, loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. 111 behaves as LD.
- funct3, stores: 000 SB, 001 SH, 010 SW, 011 SD. 1xx behaves as SD.
- wstrb = {0x01, 0x03, 0x0F, 0xFF}[size] << addr[2:0], truncated to 8 bits. wdata = Write_Data << 8*addr[2:0].
- Sign extension from bit 7/15/31 for signed loads; zero extension for U variants.
- out_valid is a one-cycle pulse per instruction; MEM/WB samples it on the following edge.

Optional Feature:
MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port mem_misaligned (1 bit, reset 0).
  - Misalignment: half with addr[0]≠0, word with addr[1:0]≠0, double with addr[2:0]≠0.
  - A misaligned mem op in IDLE issues no dmem_req and does not stall.
  - Next edge: out_valid=1, mem_misaligned=1 (one-cycle pulse), RegWrite_o=0, Read_Data_Memory=0.
- Undefined:
  - No port.
  - Address low bits below access size are forced to 0 (aligned down), and the access proceeds normally.

Decomposition:
- Package riscv_mem_pkg: funct3 load/store localparams, FSM state encoding (IDLE=0, WAIT=1), size-to-base-strobe constants.
- Sub-module lsu_lane_align (combinational): computes wstrb/wdata from size and offset, and performs load extract plus extend. It is instantiated once.

Test Plan:
- Non-mem op, Result=0x1234, RD=5, RegWrite=1 → next cycle out_valid=1, Result_o=0x1234, RD_o=5, stall=0, dmem_req never set.
- SB, addr=0x1003, Write_Data=0xAB, ack after 3 wait cycles → dmem_addr=0x1000, wstrb=0x08, wdata[31:24]=0xAB, stall high 4 cycles, single out_valid pulse.
- LB vs LBU, addr=0x2005, rdata byte5=0x80 → Read_Data_Memory=0xFFFF_FFFF_FFFF_FF80 / 0x80.
- LW, addr=0x10, zero-wait memory → LWU with rdata[31:0]=0x8000_0001 gives 0x0000_0000_8000_0001; the accept→out_valid gap is 2 cycles.
- reset_n low while in WAIT → dmem_req, stall, out_valid go to 0 immediately; after release, the FSM accepts a new op from IDLE.
- MEM_MISALIGN_TRAP_EN, LW at 0x102 → no dmem_req, mem_misaligned=1 and RegWrite_o=0 next cycle. Without the macro → dmem_addr=0x100, wstrb n/a, load from 0x100.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - funct3 encodings, LSU FSM states and lane-strobe helpers
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

  function automatic logic [7:0] size_strobe(input logic [1:0] size);
    case (size)
      SZ_B:    return STRB_B;
      SZ_H:    return STRB_H;
      SZ_W:    return STRB_W;
      default: return STRB_D;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane placement of store data and load extract/extend
module lsu_lane_align
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      size,
  input  logic [2:0]      offset,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [7:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ldata
);

  logic [XLEN-1:0] shifted;

  assign wstrb   = size_strobe(size) << offset;
  assign wdata   = store_data << {offset, 3'b000};
  assign shifted = load_word >> {offset, 3'b000};

  always_comb begin
    ldata = shifted;
    case (size)
      SZ_B: ldata = {{(XLEN-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_H: ldata = {{(XLEN-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
      SZ_W: ldata = {{(XLEN-32){~is_unsigned & shifted[31]}}, shifted[31:0]};
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit with req/ack data-memory port
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses retire with mem_misaligned instead of aligning down.
module mem_stage_lsu
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            RegWrite,
  input  logic            MemtoReg,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] Result,
  input  logic [XLEN-1:0] Write_Data,
  input  logic [4:0]      RD,
  output logic            stall,
  output logic            out_valid,
  output logic            RegWrite_o,
  output logic            MemtoReg_o,
  output logic [XLEN-1:0] Read_Data_Memory,
  output logic [XLEN-1:0] Result_o,
  output logic [4:0]      RD_o,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic            mem_misaligned,
`endif
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wstrb,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
);

  lsu_state_e      state_q;
  logic [1:0]      size_q;
  logic [2:0]      offset_q;
  logic            unsigned_q, we_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [7:0]      wstrb_q;
  logic            out_valid_q, regwrite_q, memtoreg_q;
  logic [XLEN-1:0] rdm_q, result_q;
  logic [4:0]      rd_q;

  logic            mem_op, accept, trap, misaligned_in, unsigned_in;
  logic [1:0]      size_in, size_sel;
  logic [2:0]      mask_in, offset_in, offset_sel;
  logic [7:0]      wstrb_a;
  logic [XLEN-1:0] wdata_a, ldata_a;

  // Stores win when both MemRead and MemWrite are set; store funct3 1xx is SD.
  assign mem_op        = in_valid & (MemRead | MemWrite);
  assign size_in       = (MemWrite & funct3[2]) ? SZ_D : funct3[1:0];
  assign unsigned_in   = ~MemWrite & (funct3 == F3_LBU || funct3 == F3_LHU || funct3 == F3_LWU);
  assign mask_in       = size_mask(size_in);
  assign misaligned_in = |(Result[2:0] & mask_in);
  assign offset_in     = Result[2:0] & ~mask_in;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned_q;
  assign trap           = mem_op & misaligned_in;
  assign mem_misaligned = misaligned_q;
`else
  assign trap = 1'b0;
  logic unused_misaligned;
  assign unused_misaligned = misaligned_in;
`endif

  assign accept = mem_op & ~trap;

  // One aligner: fed from the live inputs at accept, from the latched request at ack.
  assign size_sel   = (state_q == ST_WAIT) ? size_q : size_in;
  assign offset_sel = (state_q == ST_WAIT) ? offset_q : offset_in;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .size        (size_sel),
    .offset      (offset_sel),
    .is_unsigned (unsigned_q),
    .store_data  (Write_Data),
    .load_word   (dmem_rdata),
    .wstrb       (wstrb_a),
    .wdata       (wdata_a),
    .ldata       (ldata_a)
  );

  assign stall            = (state_q == ST_IDLE) ? accept : ~dmem_ack;
  assign dmem_req         = (state_q == ST_WAIT);
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_wstrb       = wstrb_q;
  assign out_valid        = out_valid_q;
  assign RegWrite_o       = regwrite_q;
  assign MemtoReg_o       = memtoreg_q;
  assign Read_Data_Memory = rdm_q;
  assign Result_o         = result_q;
  assign RD_o             = rd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      size_q      <= '0;
      offset_q    <= '0;
      unsigned_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      out_valid_q <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      rdm_q       <= '0;
      result_q    <= '0;
      rd_q        <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          regwrite_q <= RegWrite;
          memtoreg_q <= MemtoReg;
          result_q   <= Result;
          rd_q       <= RD;
          rdm_q      <= '0;
          if (trap) begin
            out_valid_q <= 1'b1;
            regwrite_q  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned_q <= 1'b1;
`endif
          end else if (accept) begin
            state_q    <= ST_WAIT;
            size_q     <= size_in;
            offset_q   <= offset_in;
            unsigned_q <= unsigned_in;
            we_q       <= MemWrite;
            addr_q     <= {Result[XLEN-1:3], 3'b000};
            wdata_q    <= wdata_a;
            wstrb_q    <= wstrb_a;
          end else begin
            out_valid_q <= in_valid;
          end
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            out_valid_q <= 1'b1;
            rdm_q       <= we_q ? '0 : ldata_a;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed vector bench for mem_stage_lsu
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, RegWrite = 1'b0, MemtoReg = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [63:0] Result = '0, Write_Data = '0;
  logic [4:0]  RD = '0;
  logic        stall, out_valid, RegWrite_o, MemtoReg_o;
  logic [63:0] Read_Data_Memory, Result_o;
  logic [4:0]  RD_o;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [63:0] dmem_rdata = '0;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mem_misaligned;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(64)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .funct3(funct3), .Result(Result),
    .Write_Data(Write_Data), .RD(RD), .stall(stall), .out_valid(out_valid),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .Read_Data_Memory(Read_Data_Memory),
    .Result_o(Result_o), .RD_o(RD_o),
`ifdef MEM_MISALIGN_TRAP_EN
    .mem_misaligned(mem_misaligned),
`endif
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] rdata;
    int          waits;
    logic [63:0] exp_addr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [63:0] addr,
                              logic [63:0] wd, logic [63:0] rdata, int waits,
                              logic [63:0] exp_addr, logic [7:0] exp_strb,
                              logic [63:0] exp_wdata, logic [63:0] exp_rdm);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
    v.waits = waits; v.exp_addr = exp_addr; v.exp_strb = exp_strb;
    v.exp_wdata = exp_wdata; v.exp_rdm = exp_rdm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stall_cnt;
    stall_cnt = 0;
    @(negedge clk);
    in_valid = 1'b1; MemRead = v.rd; MemWrite = v.wr; RegWrite = v.rd & ~v.wr;
    MemtoReg = v.rd; funct3 = v.f3; Result = v.addr; Write_Data = v.wd;
    RD = idx[4:0]; dmem_ack = 1'b0; dmem_rdata = '0;
    #1 if (stall) stall_cnt++;
    @(posedge clk); #1;
    chk($sformatf("v%0d_req", idx), {63'd0, dmem_req}, 64'd1);
    chk($sformatf("v%0d_addr", idx), dmem_addr, v.exp_addr);
    chk($sformatf("v%0d_we", idx), {63'd0, dmem_we}, {63'd0, v.wr});
    if (v.wr) begin
      chk($sformatf("v%0d_wstrb", idx), {56'd0, dmem_wstrb}, {56'd0, v.exp_strb});
      chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.exp_wdata);
    end
    chk($sformatf("v%0d_ov_accept", idx), {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0; funct3 = 3'b101; Result = '1; Write_Data = '1; MemWrite = ~v.wr;
    for (int k = 0; k < v.waits; k++) begin
      #1 if (stall) stall_cnt++;
      @(negedge clk);
    end
    dmem_ack = 1'b1; dmem_rdata = v.rdata;
    #1;
    chk($sformatf("v%0d_stall_ack", idx), {63'd0, stall}, 64'd0);
    chk($sformatf("v%0d_stall_cycles", idx), 64'(stall_cnt), 64'(v.waits + 1));
    chk($sformatf("v%0d_addr_hold", idx), dmem_addr, v.exp_addr);
    @(posedge clk); #1;
    chk($sformatf("v%0d_ov", idx), {63'd0, out_valid}, 64'd1);
    chk($sformatf("v%0d_rdm", idx), Read_Data_Memory, v.exp_rdm);
    chk($sformatf("v%0d_rd_o", idx), {59'd0, RD_o}, 64'(idx[4:0]));
    chk($sformatf("v%0d_result_o", idx), Result_o, v.addr);
    chk($sformatf("v%0d_regwrite_o", idx), {63'd0, RegWrite_o}, {63'd0, v.rd & ~v.wr});
    chk($sformatf("v%0d_req_done", idx), {63'd0, dmem_req}, 64'd0);
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = '0;
    @(posedge clk); #1;
    chk($sformatf("v%0d_ov_pulse", idx), {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    vecs.push_back(mk(0, 1, 3'b000, 64'h1003, 64'hAB, 64'h0, 3, 64'h1000, 8'h08, 64'h0000_0000_AB00_0000, 64'h0));
    vecs.push_back(mk(1, 0, 3'b000, 64'h2005, 64'h0, 64'h1122_8033_4455_6677, 1, 64'h2000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80));
    vecs.push_back(mk(1, 0, 3'b100, 64'h2005, 64'h0, 64'h1122_8033_4455_6677, 0, 64'h2000, 8'h00, 64'h0, 64'h0000_0000_0000_0080));
    vecs.push_back(mk(1, 0, 3'b110, 64'h0010, 64'h0, 64'hDEAD_BEEF_8000_0001, 0, 64'h0010, 8'h00, 64'h0, 64'h0000_0000_8000_0001));
    vecs.push_back(mk(1, 0, 3'b010, 64'h0010, 64'h0, 64'hDEAD_BEEF_8000_0001, 0, 64'h0010, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0001));
    vecs.push_back(mk(1, 0, 3'b001, 64'h2006, 64'h0, 64'h8123_4567_89AB_CDEF, 1, 64'h2000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8123));
    vecs.push_back(mk(1, 0, 3'b101, 64'h2006, 64'h0, 64'h8123_4567_89AB_CDEF, 1, 64'h2000, 8'h00, 64'h0, 64'h0000_0000_0000_8123));
    vecs.push_back(mk(1, 0, 3'b011, 64'h3000, 64'h0, 64'h8123_4567_89AB_CDEF, 2, 64'h3000, 8'h00, 64'h0, 64'h8123_4567_89AB_CDEF));
    vecs.push_back(mk(1, 0, 3'b111, 64'h3008, 64'h0, 64'h8123_4567_89AB_CDEF, 0, 64'h3008, 8'h00, 64'h0, 64'h8123_4567_89AB_CDEF));
    vecs.push_back(mk(0, 1, 3'b001, 64'h4006, 64'h1234_5678, 64'h0, 1, 64'h4000, 8'hC0, 64'h5678_0000_0000_0000, 64'h0));
    vecs.push_back(mk(0, 1, 3'b010, 64'h4004, 64'hAABB_CCDD_1122_3344, 64'h0, 0, 64'h4000, 8'hF0, 64'h1122_3344_0000_0000, 64'h0));
    vecs.push_back(mk(0, 1, 3'b011, 64'h4000, 64'h0102_0304_0506_0708, 64'h0, 2, 64'h4000, 8'hFF, 64'h0102_0304_0506_0708, 64'h0));
    vecs.push_back(mk(0, 1, 3'b100, 64'h4008, 64'hCAFE, 64'h0, 0, 64'h4008, 8'hFF, 64'hCAFE, 64'h0));
    vecs.push_back(mk(1, 1, 3'b000, 64'h4001, 64'h5A, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h4000, 8'h02, 64'h5A00, 64'h0));
`ifndef MEM_MISALIGN_TRAP_EN
    vecs.push_back(mk(1, 0, 3'b010, 64'h0102, 64'h0, 64'h1111_2222_F000_0001, 0, 64'h0100, 8'h00, 64'h0, 64'hFFFF_FFFF_F000_0001));
    vecs.push_back(mk(0, 1, 3'b001, 64'h4003, 64'hBEEF, 64'h0, 1, 64'h4000, 8'h0C, 64'h0000_0000_BEEF_0000, 64'h0));
`endif

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {63'd0, dmem_req}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_ov", {63'd0, out_valid}, 64'd0);
    chk("rst_addr", dmem_addr, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Non-memory instruction passes straight through in one cycle.
    @(negedge clk);
    in_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b1; MemtoReg = 1'b0;
    Result = 64'h1234; RD = 5'd5; dmem_ack = 1'b1;
    #1;
    chk("nm_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    chk("nm_ov", {63'd0, out_valid}, 64'd1);
    chk("nm_result", Result_o, 64'h1234);
    chk("nm_rd", {59'd0, RD_o}, 64'd5);
    chk("nm_regwrite", {63'd0, RegWrite_o}, 64'd1);
    chk("nm_req", {63'd0, dmem_req}, 64'd0);
    chk("nm_rdm", Read_Data_Memory, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("nm_ov_pulse", {63'd0, out_valid}, 64'd0);
    chk("idle_ack_ignored", {63'd0, dmem_req}, 64'd0);
    @(negedge clk);
    dmem_ack = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset while a store is outstanding abandons it.
    @(negedge clk);
    in_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; funct3 = 3'b000;
    Result = 64'h1003; Write_Data = 64'hAB;
    @(posedge clk); #1;
    chk("rw_req", {63'd0, dmem_req}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rw_req_async", {63'd0, dmem_req}, 64'd0);
    chk("rw_stall_async", {63'd0, stall}, 64'd0);
    chk("rw_ov_async", {63'd0, out_valid}, 64'd0);
    chk("rw_wstrb_async", {56'd0, dmem_wstrb}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_vec(vecs[3], 20);

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1; MemtoReg = 1'b1;
    funct3 = 3'b010; Result = 64'h0102; RD = 5'd9;
    #1;
    chk("mis_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    chk("mis_req", {63'd0, dmem_req}, 64'd0);
    chk("mis_ov", {63'd0, out_valid}, 64'd1);
    chk("mis_flag", {63'd0, mem_misaligned}, 64'd1);
    chk("mis_regwrite", {63'd0, RegWrite_o}, 64'd0);
    chk("mis_rdm", Read_Data_Memory, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mis_flag_pulse", {63'd0, mem_misaligned}, 64'd0);
    chk("mis_ov_pulse", {63'd0, out_valid}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
